mf_cegen_nco: RTL and testbench

Multi-channel numerically-controlled clock-enable generator. It is the fabric-side successor to the fixed-ratio PLL wrappers: it derives up to CHANNELS phase-related clock enables and square waves from one reference clock, using a shared, runtime-reprogrammable fractional increment. Typical use is a 5.369318 MHz pixel/chroma enable plus a quarter-period-lagged companion, generated from the 74.25 MHz video clock, without consuming a PLL. Frequency changes are glitch-free and applied at a channel-0 wrap; a lock flag qualifies the outputs after each start or retune.

---
 rtl/mf_cegen_nco.sv | 121 ++++++++++++
 tb/tb_mf_cegen_nco.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_cegen_nco.sv
// Multi-channel NCO clock-enable generator: shared fractional increment, per-channel
// phase offsets, retune applied glitch-free at a channel-0 wrap, lock after N wraps.
module mf_cegen_nco #(
    parameter int unsigned                   ACC_WIDTH  = 32,
    parameter int unsigned                   CHANNELS   = 2,
    parameter logic [ACC_WIDTH-1:0]          INC_RESET  = 32'd310586481,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] PHASE      = {32'hC000_0000, 32'h0000_0000},
    parameter int unsigned                   LOCK_WRAPS = 4
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic                 cfg_ready,
    output logic [CHANNELS-1:0]  ce,
    output logic [CHANNELS-1:0]  clk_out,
    output logic                 locked
);
    localparam logic [CHANNELS-1:0][ACC_WIDTH-1:0] PHASE_ARR   = PHASE;
    localparam logic [7:0]                         LOCK_TARGET = 8'(LOCK_WRAPS);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t                             state_q, state_d;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0]               inc_q, inc_d;
    logic [ACC_WIDTH-1:0]               pend_inc_q, pend_inc_d;
    logic [7:0]                         lock_cnt_q, lock_cnt_d;
    logic [CHANNELS-1:0]                ce_q, ce_d;
    logic [CHANNELS-1:0]                clk_out_q, clk_out_d;
    logic                               locked_q, locked_d;
    logic                               applied_q, applied_d;

    logic [CHANNELS-1:0][ACC_WIDTH-1:0] sum;
    logic [CHANNELS-1:0]                carry;
    logic [CHANNELS-1:0]                phase_msb;
    logic                               inc_zero;
    logic                               accept;
    logic                               apply;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            {carry[k], sum[k]} = {1'b0, acc_q[k]} + {1'b0, inc_q};
            phase_msb[k]       = PHASE_ARR[k][ACC_WIDTH-1];
        end
    end

    // A frozen accumulator never wraps, so a pending retune must not wait for a carry.
    assign inc_zero = (inc_q == '0);
    assign accept   = cfg_valid && (state_q == ST_IDLE);
    assign apply    = (state_q == ST_PEND) && (carry[0] || inc_zero);

    always_comb begin
        state_d    = state_q;
        acc_d      = sum;
        inc_d      = inc_q;
        pend_inc_d = pend_inc_q;
        ce_d       = carry;
        applied_d  = 1'b0;
        lock_cnt_d = lock_cnt_q;
        for (int k = 0; k < CHANNELS; k++) begin
            clk_out_d[k] = sum[k][ACC_WIDTH-1];
        end

        // The pulse produced by an apply restarts the count rather than advancing it.
        if (ce_q[0] && !applied_q && (lock_cnt_q != LOCK_TARGET)) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
        locked_d = (lock_cnt_d == LOCK_TARGET) && !inc_zero;

        if (accept) begin
            state_d    = ST_PEND;
            pend_inc_d = cfg_inc;
        end

        if (apply) begin
            state_d    = ST_IDLE;
            acc_d      = PHASE_ARR;
            inc_d      = pend_inc_q;
            ce_d       = '0;
            ce_d[0]    = 1'b1;
            clk_out_d  = phase_msb;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            applied_d  = 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= PHASE_ARR;
            inc_q      <= INC_RESET;
            pend_inc_q <= '0;
            lock_cnt_q <= '0;
            ce_q       <= '0;
            clk_out_q  <= phase_msb;
            locked_q   <= 1'b0;
            applied_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_inc_q <= pend_inc_d;
            lock_cnt_q <= lock_cnt_d;
            ce_q       <= ce_d;
            clk_out_q  <= clk_out_d;
            locked_q   <= locked_d;
            applied_q  <= applied_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign ce        = ce_q;
    assign clk_out   = clk_out_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_mf_cegen_nco.sv
// Directed bench for mf_cegen_nco: an 8-bit instance driven from hand-computed
// per-cycle tables, plus a default-width instance checked for rate and phase lag.
`timescale 1ns/1ps
module tb_mf_cegen_nco;

    typedef struct {
        logic       cfgValid;
        logic [7:0] cfgInc;
        logic [1:0] expCe;
        logic [1:0] expClk;
        logic       expReady;
        logic       expLocked;
    } vec_t;

    logic        refclk   = 1'b0;
    logic        rst      = 1'b1;
    logic        cfgValid = 1'b0;
    logic [7:0]  cfgInc   = 8'd0;
    logic        cfgReady;
    logic [1:0]  ce;
    logic [1:0]  clkOut;
    logic        locked;

    logic        cfgValid32 = 1'b0;
    logic [31:0] cfgInc32   = 32'd0;
    logic        cfgReady32;
    logic [1:0]  ce32;
    logic [1:0]  clkOut32;
    logic        locked32;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    vec_t vecs[$];

    always #5 refclk = ~refclk;

    mf_cegen_nco #(
        .ACC_WIDTH (8),
        .CHANNELS  (2),
        .INC_RESET (8'd64),
        .PHASE     (16'hC000),
        .LOCK_WRAPS(2)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfgValid),
        .cfg_inc  (cfgInc),
        .cfg_ready(cfgReady),
        .ce       (ce),
        .clk_out  (clkOut),
        .locked   (locked)
    );

    mf_cegen_nco dut32 (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfgValid32),
        .cfg_inc  (cfgInc32),
        .cfg_ready(cfgReady32),
        .ce       (ce32),
        .clk_out  (clkOut32),
        .locked   (locked32)
    );

    task automatic nextCycle();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        cfgValid = 1'b0;
        cfgInc   = 8'd0;
        @(posedge refclk);
        @(posedge refclk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic checkBits(input string name, input logic [1:0] act, input logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic addVec(input logic v, input logic [7:0] inc, input logic [1:0] c,
                          input logic [1:0] k, input logic r, input logic l);
        vec_t t;
        t.cfgValid  = v;
        t.cfgInc    = inc;
        t.expCe     = c;
        t.expClk    = k;
        t.expReady  = r;
        t.expLocked = l;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        cfgValid = v.cfgValid;
        cfgInc   = v.cfgInc;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkBits({tag, ".ce"}, ce, v.expCe);
        checkBits({tag, ".clk_out"}, clkOut, v.expClk);
        checkBits({tag, ".cfg_ready"}, {1'b0, cfgReady}, {1'b0, v.expReady});
        checkBits({tag, ".locked"}, {1'b0, locked}, {1'b0, v.expLocked});
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(tag, vecs[i]);
            nextCycle();
        end
        cfgValid = 1'b0;
        vecs.delete();
    endtask

    // Free-running inc=64: ce0 at 4,8,12; ce1 at 1,5,9,13; locked from cycle 9.
    task automatic loadBasic();
        addVec(1'b0, 8'd0, 2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 1'b1);
        addVec(1'b0, 8'd0, 2'b00, 2'b01, 1'b1, 1'b1);
        addVec(1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 1'b1);
        addVec(1'b0, 8'd0, 2'b01, 2'b10, 1'b1, 1'b1);
        addVec(1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 1'b1);
    endtask

    initial begin
        int     n32;
        int     ce0Count;
        int     lastCe0;
        int     gap;
        int     doublePulses;
        logic   prevCe0;
        longint expCount;
        longint diff;

        // Scenario: reset values and free-running output pattern.
        doReset();
        loadBasic();
        runTable("basic");

        // Scenario: retune to 32 offered in cycle 2, applied at the wrap ending cycle 3.
        doReset();
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b1, 8'd32, 2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b1);
        runTable("retune32");

        // Scenario: freeze with inc=0, then restart with inc=64 right after its accept.
        doReset();
        addVec(1'b1, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b10, 2'b00, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b1, 8'd64, 2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b10, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b00, 2'b11, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,  2'b01, 2'b10, 1'b1, 1'b0);
        runTable("freeze");

        // Scenario: cfg_valid held through a pending retune; 128 waits for cfg_ready.
        doReset();
        addVec(1'b0, 8'd0,   2'b00, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,   2'b10, 2'b00, 1'b1, 1'b0);
        addVec(1'b1, 8'd32,  2'b00, 2'b01, 1'b1, 1'b0);
        addVec(1'b1, 8'd128, 2'b00, 2'b11, 1'b0, 1'b0);
        addVec(1'b1, 8'd128, 2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b10, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b10, 2'b00, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b00, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b01, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b01, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b11, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b00, 2'b11, 1'b0, 1'b0);
        addVec(1'b0, 8'd0,   2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,   2'b10, 2'b01, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,   2'b01, 2'b10, 1'b1, 1'b0);
        addVec(1'b0, 8'd0,   2'b10, 2'b01, 1'b1, 1'b0);
        runTable("backToBack");

        // Scenario: one-cycle reset while a retune is pending discards it.
        doReset();
        cfgValid = 1'b1;
        cfgInc   = 8'd32;
        checkBits("rstPend.readyBefore", {1'b0, cfgReady}, 2'b01);
        nextCycle();
        cfgValid = 1'b0;
        cfgInc   = 8'd0;
        checkBits("rstPend.readyPending", {1'b0, cfgReady}, 2'b00);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        cyc = 0;
        loadBasic();
        runTable("rstPend");

        // Scenario: default 32-bit instance, rate and quarter-period lag of channel 1.
        doReset();
        n32          = 20000;
        ce0Count     = 0;
        lastCe0      = -1;
        doublePulses = 0;
        prevCe0      = 1'b0;
        for (int n = 0; n < n32; n++) begin
            if (ce32[1] && (lastCe0 >= 0)) begin
                gap = n - lastCe0;
                compared++;
                if ((gap < 3) || (gap > 4)) begin
                    mismatched++;
                    $display("[TB] FAIL lag32 cycle %0d: got gap %0d, expected 3 or 4", n, gap);
                end
            end
            if (ce32[0]) begin
                if (prevCe0) doublePulses++;
                ce0Count++;
                lastCe0 = n;
            end
            prevCe0 = ce32[0];
            nextCycle();
        end
        expCount = (longint'(n32) * 64'd310586481) >>> 32;
        diff     = longint'(ce0Count) - expCount;
        compared++;
        if ((diff < -1) || (diff > 1)) begin
            mismatched++;
            $display("[TB] FAIL rate32: got %0d ce0 pulses, expected %0d +/-1", ce0Count, expCount);
        end
        compared++;
        if (doublePulses != 0) begin
            mismatched++;
            $display("[TB] FAIL width32: got %0d multi-cycle ce0 pulses, expected 0", doublePulses);
        end
        checkBits("locked32", {1'b0, locked32}, 2'b01);
        checkBits("ready32", {1'b0, cfgReady32}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
